// File: rtl/peripheral_counter_core_if.sv
// Native register interface between the peripheral register map and the counter core.
// The master modport is the register map side; the slave modport is the core side.
interface peripheral_counter_core_if;
    logic        count_we;
    logic [31:0] count_in;
    logic [31:0] count_out;
    logic        config_we;
    logic        en_in;
    logic        dir_in;
    logic        ire_in;
    logic        en_out;
    logic        dir_out;
    logic        ire_out;
    logic        lt_1k_out;
    logic        irq;
    logic        irq_ack;

    modport master (
        output count_we, count_in, config_we, en_in, dir_in, ire_in, irq_ack,
        input  count_out, en_out, dir_out, ire_out, lt_1k_out, irq
    );

    modport slave (
        input  count_we, count_in, config_we, en_in, dir_in, ire_in, irq_ack,
        output count_out, en_out, dir_out, ire_out, lt_1k_out, irq
    );
endinterface

// File: rtl/peripheral_counter_core.sv
// Prescaled 32-bit up/down counter with config, status flag and wrap interrupt.
// Optional PERIPHERAL_COUNTER_ONESHOT_EN: saturate at the terminal value and clear en on wrap.
module peripheral_counter_core #(
    parameter int unsigned PRESCALE     = 1,
    parameter logic [31:0] LT_THRESHOLD = 32'd1000
) (
    input  logic                     clk,
    input  logic                     reset,
    peripheral_counter_core_if.slave bus
);
    localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [31:0]   count_q;
    logic [31:0]   count_step;
    logic [PW-1:0] pre_q;
    logic          en_q;
    logic          dir_q;
    logic          ire_q;
    logic          pending_q;
    logic          step;
    logic          at_term;
    logic          wrap;

    always_comb begin
        step       = en_q && (pre_q == PRE_LAST);
        at_term    = dir_q ? (&count_q) : ~(|count_q);
        // A register write in the same cycle overrides the step, so it can never wrap.
        wrap       = step && !bus.count_we && at_term;
        count_step = dir_q ? (count_q + 32'd1) : (count_q - 32'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre_q <= '0;
        else if (bus.count_we || !en_q || step)
            pre_q <= '0;
        else
            pre_q <= pre_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else if (bus.count_we)
            count_q <= bus.count_in;
`ifdef PERIPHERAL_COUNTER_ONESHOT_EN
        else if (step && !wrap)
            count_q <= count_step;
`else
        else if (step)
            count_q <= count_step;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q  <= 1'b0;
            dir_q <= 1'b0;
            ire_q <= 1'b0;
        end else if (bus.config_we) begin
            en_q  <= bus.en_in;
            dir_q <= bus.dir_in;
            ire_q <= bus.ire_in;
        end
`ifdef PERIPHERAL_COUNTER_ONESHOT_EN
        else if (wrap) begin
            en_q  <= 1'b0;
        end
`endif
    end

    // Set has priority over acknowledge so a wrap coincident with irq_ack is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending_q <= 1'b0;
        else if (wrap && ire_q)
            pending_q <= 1'b1;
        else if (bus.irq_ack)
            pending_q <= 1'b0;
    end

    assign bus.count_out = count_q;
    assign bus.en_out    = en_q;
    assign bus.dir_out   = dir_q;
    assign bus.ire_out   = ire_q;
    assign bus.lt_1k_out = (count_q < LT_THRESHOLD);
    assign bus.irq       = pending_q & ire_q;
endmodule

// File: tb/tb_peripheral_counter_core.sv
// Randomized self-checking bench: two cores (PRESCALE 1 and 4) share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_peripheral_counter_core;
    logic        clk;
    logic        reset;
    logic        count_we, config_we, en_in, dir_in, ire_in, irq_ack;
    logic [31:0] count_in;

    int vecs = 0;
    int errs = 0;

    peripheral_counter_core_if bus1 ();
    peripheral_counter_core_if bus4 ();

    assign bus1.count_we = count_we;  assign bus4.count_we = count_we;
    assign bus1.count_in = count_in;  assign bus4.count_in = count_in;
    assign bus1.config_we = config_we; assign bus4.config_we = config_we;
    assign bus1.en_in = en_in;        assign bus4.en_in = en_in;
    assign bus1.dir_in = dir_in;      assign bus4.dir_in = dir_in;
    assign bus1.ire_in = ire_in;      assign bus4.ire_in = ire_in;
    assign bus1.irq_ack = irq_ack;    assign bus4.irq_ack = irq_ack;

    peripheral_counter_core #(.PRESCALE(1), .LT_THRESHOLD(32'd1000)) u_p1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    peripheral_counter_core #(.PRESCALE(4), .LT_THRESHOLD(32'd1000)) u_p4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: enabled-cycle tally, wide signed arithmetic for wrap detection.
    logic [31:0] m_count [2];
    bit          m_en [2], m_dir [2], m_ire [2], m_pend [2];
    int          m_run [2];

    function automatic int ps(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = '0; m_en[k] = 0; m_dir[k] = 0; m_ire[k] = 0; m_pend[k] = 0; m_run[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit     stp, wrp;
            longint nxt;
            stp = 0; wrp = 0;
            if (m_en[k]) begin
                m_run[k]++;
                if (m_run[k] >= ps(k)) begin stp = 1; m_run[k] = 0; end
            end else
                m_run[k] = 0;
            if (count_we) begin
                m_run[k]   = 0;
                m_count[k] = count_in;
            end else if (stp) begin
                nxt = longint'(m_count[k]) + (m_dir[k] ? 64'sd1 : -64'sd1);
                wrp = (nxt < 0) || (nxt > 64'sh0FFFFFFFF);
`ifdef PERIPHERAL_COUNTER_ONESHOT_EN
                if (!wrp) m_count[k] = nxt[31:0];
`else
                m_count[k] = nxt[31:0];
`endif
            end
            if (wrp && m_ire[k]) m_pend[k] = 1;
            else if (irq_ack)    m_pend[k] = 0;
            if (config_we) begin
                m_en[k] = en_in; m_dir[k] = dir_in; m_ire[k] = ire_in;
            end
`ifdef PERIPHERAL_COUNTER_ONESHOT_EN
            else if (wrp) m_en[k] = 0;
`endif
        end
    endtask

    function automatic logic [36:0] exp_vec(int k);
        return {m_count[k], m_en[k], m_dir[k], m_ire[k], (m_count[k] < 32'd1000), m_pend[k] & m_ire[k]};
    endfunction

    function automatic logic [36:0] dut_vec(int k);
        if (k == 0)
            return {bus1.count_out, bus1.en_out, bus1.dir_out, bus1.ire_out, bus1.lt_1k_out, bus1.irq};
        return {bus4.count_out, bus4.en_out, bus4.dir_out, bus4.ire_out, bus4.lt_1k_out, bus4.irq};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_strobes();
        count_we = 0; config_we = 0; irq_ack = 0;
    endtask

    task automatic set_cfg(bit en, bit dir, bit ire);
        config_we = 1; en_in = en; dir_in = dir; ire_in = ire;
        tick();
        config_we = 0;
    endtask

    task automatic write_count(logic [31:0] v);
        count_we = 1; count_in = v;
        tick();
        count_we = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (dut_vec(k) !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                    errs++; $display("FAIL reset_state inst=%0d got=%h exp=%h", k, dut_vec(k), {32'd0, 5'b00010});
                end
            end
        end
    endtask

    task automatic test_count_up();
        write_count(32'd998);
        set_cfg(1, 1, 0);
        vecs++;
        if (bus1.en_out !== 1'b1 || bus1.count_out !== 32'd998) begin
            errs++; $display("FAIL cfg_latency got en=%b cnt=%0d exp en=1 cnt=998", bus1.en_out, bus1.count_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (bus1.count_out !== 32'(999 + i) || bus1.lt_1k_out !== (i == 0)) begin
                errs++; $display("FAIL count_up step%0d got cnt=%0d lt=%b exp cnt=%0d lt=%b",
                                 i, bus1.count_out, bus1.lt_1k_out, 999 + i, (i == 0));
            end
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    errs++; $display("FAIL count_up_model inst=%0d got=%h exp=%h", k, dut_vec(k), exp_vec(k));
                end
            end
        end
        set_cfg(0, 1, 0);
    endtask

    task automatic test_prescale();
        write_count(32'd10);
        set_cfg(1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            vecs++;
            if (bus4.count_out !== 32'(10 - i / 4)) begin
                errs++; $display("FAIL prescale_run cyc%0d got=%0d exp=%0d", i, bus4.count_out, 10 - i / 4);
            end
        end
        set_cfg(0, 0, 0);
        tick(); tick();
        set_cfg(1, 0, 0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            vecs++;
            if (bus4.count_out !== ((j < 4) ? 32'd8 : 32'd7)) begin
                errs++; $display("FAIL prescale_reenable cyc%0d got=%0d exp=%0d", j, bus4.count_out, (j < 4) ? 8 : 7);
            end
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    errs++; $display("FAIL prescale_model inst=%0d got=%h exp=%h", k, dut_vec(k), exp_vec(k));
                end
            end
        end
        set_cfg(0, 0, 0);
    endtask

    task automatic test_write_priority();
        set_cfg(1, 1, 0);
        write_count(32'd500);
        vecs++;
        if (bus1.count_out !== 32'd500) begin
            errs++; $display("FAIL write_over_step500 got=%0d exp=500", bus1.count_out);
        end
        write_count(32'd7);
        vecs++;
        if (bus1.count_out !== 32'd7) begin
            errs++; $display("FAIL write_over_step7 got=%0d exp=7", bus1.count_out);
        end
        set_cfg(0, 1, 0);
    endtask

    task automatic test_wrap_irq();
        write_count(32'hFFFF_FFFE);
        set_cfg(1, 1, 1);
        tick();
        vecs++;
        if (bus1.count_out !== 32'hFFFF_FFFF || bus1.irq !== 1'b0) begin
            errs++; $display("FAIL pre_wrap got cnt=%h irq=%b exp cnt=ffffffff irq=0", bus1.count_out, bus1.irq);
        end
        tick();
`ifdef PERIPHERAL_COUNTER_ONESHOT_EN
        vecs++;
        if (bus1.count_out !== 32'hFFFF_FFFF || bus1.irq !== 1'b1 || bus1.en_out !== 1'b0) begin
            errs++; $display("FAIL wrap_up got cnt=%h irq=%b en=%b exp cnt=ffffffff irq=1 en=0",
                             bus1.count_out, bus1.irq, bus1.en_out);
        end
`else
        vecs++;
        if (bus1.count_out !== 32'd0 || bus1.irq !== 1'b1 || bus1.en_out !== 1'b1) begin
            errs++; $display("FAIL wrap_up got cnt=%h irq=%b en=%b exp cnt=0 irq=1 en=1",
                             bus1.count_out, bus1.irq, bus1.en_out);
        end
`endif
        irq_ack = 1; tick(); irq_ack = 0;
        vecs++;
        if (bus1.irq !== 1'b0) begin
            errs++; $display("FAIL irq_ack got=%b exp=0", bus1.irq);
        end
        set_cfg(0, 1, 1);
        write_count(32'hFFFF_FFFF);
        set_cfg(1, 1, 1);
        irq_ack = 1; tick(); irq_ack = 0;
        vecs++;
        if (bus1.irq !== 1'b1) begin
            errs++; $display("FAIL wrap_and_ack got=%b exp=1", bus1.irq);
        end
        set_cfg(0, 1, 0);
        vecs++;
        if (bus1.irq !== 1'b0) begin
            errs++; $display("FAIL irq_mask got=%b exp=0", bus1.irq);
        end
        set_cfg(0, 1, 1);
        vecs++;
        if (bus1.irq !== 1'b1) begin
            errs++; $display("FAIL irq_unmask got=%b exp=1", bus1.irq);
        end
        for (int k = 0; k < 2; k++) begin
            vecs++;
            if (dut_vec(k) !== exp_vec(k)) begin
                errs++; $display("FAIL wrap_model inst=%0d got=%h exp=%h", k, dut_vec(k), exp_vec(k));
            end
        end
        irq_ack = 1; tick(); irq_ack = 0;
        set_cfg(0, 0, 0);
    endtask

    task automatic test_oneshot();
        write_count(32'd1);
        set_cfg(1, 0, 1);
        tick();
        vecs++;
        if (bus1.count_out !== 32'd0) begin
            errs++; $display("FAIL down_to_zero got=%h exp=0", bus1.count_out);
        end
        tick();
`ifdef PERIPHERAL_COUNTER_ONESHOT_EN
        vecs++;
        if (bus1.count_out !== 32'd0 || bus1.en_out !== 1'b0 || bus1.irq !== 1'b1) begin
            errs++; $display("FAIL oneshot_down got cnt=%h en=%b irq=%b exp cnt=0 en=0 irq=1",
                             bus1.count_out, bus1.en_out, bus1.irq);
        end
        tick();
        vecs++;
        if (bus1.count_out !== 32'd0) begin
            errs++; $display("FAIL oneshot_hold got=%h exp=0", bus1.count_out);
        end
`else
        vecs++;
        if (bus1.count_out !== 32'hFFFF_FFFF || bus1.en_out !== 1'b1 || bus1.irq !== 1'b1) begin
            errs++; $display("FAIL wrap_down got cnt=%h en=%b irq=%b exp cnt=ffffffff en=1 irq=1",
                             bus1.count_out, bus1.en_out, bus1.irq);
        end
`endif
        irq_ack = 1; tick(); irq_ack = 0;
        set_cfg(0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] pick [8];
        pick = '{32'h0, 32'h1, 32'h2, 32'd998, 32'd1001, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 600; i++) begin
            count_we  = ($urandom_range(0, 11) == 0);
            count_in  = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : $urandom;
            config_we = ($urandom_range(0, 7) == 0);
            en_in     = ($urandom_range(0, 3) != 0);
            dir_in    = $urandom_range(0, 1);
            ire_in    = ($urandom_range(0, 3) != 0);
            irq_ack   = ($urandom_range(0, 5) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                vecs++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    errs++; $display("FAIL random cyc%0d inst=%0d got=%h exp=%h", i, k, dut_vec(k), exp_vec(k));
                end
            end
        end
        idle_strobes();
    endtask

    task automatic test_mid_reset();
        write_count(32'd2000);
        set_cfg(1, 1, 1);
        tick(); tick();
        #2;
        reset = 0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            vecs++;
            if (dut_vec(k) !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                errs++; $display("FAIL async_reset inst=%0d got=%h exp=%h", k, dut_vec(k), {32'd0, 5'b00010});
            end
        end
        @(negedge clk);
        reset = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            vecs++;
            if (dut_vec(k) !== exp_vec(k)) begin
                errs++; $display("FAIL post_reset inst=%0d got=%h exp=%h", k, dut_vec(k), exp_vec(k));
            end
        end
    endtask

    initial begin
        reset = 0; count_in = '0; en_in = 0; dir_in = 0; ire_in = 0;
        idle_strobes();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1;
        test_reset();
        test_count_up();
        test_prescale();
        test_write_priority();
        test_wrap_irq();
        test_oneshot();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
